// File: rtl/uart_rx_async_gen_if.sv
// Read-side bundle of uart_rx_async_gen: the FWFT FIFO head and its pop strobe.
// Handshake: rx_valid means rx_data holds the FIFO head; rd_en is the consumer's
// ready. A word is transferred on every clk edge where rx_valid and rd_en are
// both 1. rd_en while rx_valid=0 is ignored. rx_data is zero while empty.
interface uart_rx_async_gen_if #(
  parameter int MAX_BITS   = 9,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                rd_en;
  logic [MAX_BITS-1:0] rx_data;
  logic                rx_valid;
  logic [CW-1:0]       fifo_count;

  // Consumer side (APB register block / testbench)
  modport master (output rd_en, input rx_data, rx_valid, fifo_count);
  // Receiver side
  modport slave  (input rd_en, output rx_data, rx_valid, fifo_count);
endinterface

// File: rtl/uart_rx_async_gen.sv
// uart_rx_async_gen: oversampled UART receiver with per-frame data width
// (5..MAX_BITS), optional parity, 1 or 2 stop bits, false-start rejection,
// sticky error flags and a first-word-fall-through RX FIFO.
// Optional macro UART_RX_BREAK_DETECT_EN adds the break_det output and an
// IDLE-hold state that waits for the line to return high after a break.
// dbg_state exposes the FSM state encoding (IDLE=0, START=1, DATA=2,
// PARITY=3, STOP=4, HOLD=5).
module uart_rx_async_gen #(
  parameter int MAX_BITS   = 9,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic [3:0] data_bits,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       two_stop,
  input  logic       rx,
  input  logic       clr_errors,
  uart_rx_async_gen_if.slave rd_if,
  output logic       overflow,
  output logic       parity_err,
  output logic       framing_error,
  output logic       rx_idle,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic       break_det,
`endif
  output logic [2:0] dbg_state
);

  localparam int         CNTW = $clog2(OVS);
  localparam int         AW   = $clog2(FIFO_DEPTH);
  localparam int         NW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] MAXB = 4'(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  // Frame FSM state and per-frame latched configuration
  state_t              r_state, w_state_n;
  logic [CNTW-1:0]     r_cnt, w_cnt_n;
  logic [3:0]          r_bitcnt, w_bitcnt_n;
  logic [MAX_BITS-1:0] r_shift, w_shift_n;
  logic [3:0]          r_nbits, w_nbits_n;
  logic                r_par_en, w_par_en_n;
  logic                r_odd, w_odd_n;
  logic                r_two, w_two_n;
  logic                r_stop2, w_stop2_n;
  logic                r_brk, w_brk_n;
  logic [2:0]          r_samp;

  logic                w_rx_f;
  logic [3:0]          w_nbits_clamped;
  logic                w_bit_end;
  logic                w_half;
  logic                w_is_break;
  logic                w_push;
  logic [MAX_BITS-1:0] w_push_data;
  logic                w_set_par;
  logic                w_set_frm;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                w_set_brk;
  logic                r_break_det;
`endif

  // FIFO storage
  logic [MAX_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]       r_count;
  logic                w_full, w_empty, w_pop, w_wr, w_set_ovf;

  logic                r_overflow, r_parity_err, r_framing_error;

  assign w_rx_f    = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
  assign w_bit_end = (r_cnt == CNTW'(OVS - 1));
  assign w_half    = (r_cnt == CNTW'(OVS / 2 - 1));

  // Right-justify the LSB-first shift register for the latched width
  assign w_push_data = r_shift >> (MAXB - r_nbits);

`ifdef UART_RX_BREAK_DETECT_EN
  // Break: all data bits, parity bit and the first stop bit sampled low
  assign w_is_break = !r_stop2 && r_brk && !w_rx_f;
`else
  assign w_is_break = 1'b0;
`endif

  // Clamp the requested data width into 5..MAX_BITS
  always_comb begin
    w_nbits_clamped = data_bits;
    if (data_bits < 4'd5)     w_nbits_clamped = 4'd5;
    else if (data_bits > MAXB) w_nbits_clamped = MAXB;
  end

  // Next-state and per-tick actions; everything advances only on baud ticks
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_nbits_n  = r_nbits;
    w_par_en_n = r_par_en;
    w_odd_n    = r_odd;
    w_two_n    = r_two;
    w_stop2_n  = r_stop2;
    w_brk_n    = r_brk;
    w_push     = 1'b0;
    w_set_par  = 1'b0;
    w_set_frm  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    w_set_brk  = 1'b0;
`endif
    if (baud_clock) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_f) begin
            w_state_n  = S_START;
            w_cnt_n    = '0;
            w_bitcnt_n = '0;
            w_shift_n  = '0;
            w_nbits_n  = w_nbits_clamped;
            w_par_en_n = parity_en;
            w_odd_n    = odd_n_even;
            w_two_n    = two_stop;
            w_stop2_n  = 1'b0;
            w_brk_n    = 1'b1;
          end
        end
        S_START: begin
          if (w_half) begin
            w_cnt_n   = '0;
            w_state_n = w_rx_f ? S_IDLE : S_DATA;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            w_cnt_n   = '0;
            w_shift_n = {w_rx_f, r_shift[MAX_BITS-1:1]};
            if (w_rx_f) w_brk_n = 1'b0;
            if (r_bitcnt == r_nbits - 4'd1) begin
              w_bitcnt_n = '0;
              w_state_n  = r_par_en ? S_PARITY : S_STOP;
            end else begin
              w_bitcnt_n = r_bitcnt + 4'd1;
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            w_cnt_n   = '0;
            w_state_n = S_STOP;
            if (w_rx_f != ((^r_shift) ^ r_odd)) w_set_par = 1'b1;
            if (w_rx_f) w_brk_n = 1'b0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            w_cnt_n = '0;
            if (w_is_break) begin
`ifdef UART_RX_BREAK_DETECT_EN
              w_set_brk = 1'b1;
`endif
              w_state_n = S_HOLD;
            end else begin
              if (!w_rx_f) w_set_frm = 1'b1;
              if (r_two && !r_stop2) begin
                w_stop2_n = 1'b1;
              end else begin
                // Return to IDLE at the mid-stop point so a following
                // start edge is not missed
                w_push    = 1'b1;
                w_state_n = S_IDLE;
              end
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_rx_f) w_state_n = S_IDLE;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // FSM, datapath and input filter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_nbits  <= 4'd5;
      r_par_en <= 1'b0;
      r_odd    <= 1'b0;
      r_two    <= 1'b0;
      r_stop2  <= 1'b0;
      r_brk    <= 1'b0;
      r_samp   <= 3'b111;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_nbits  <= w_nbits_n;
      r_par_en <= w_par_en_n;
      r_odd    <= w_odd_n;
      r_two    <= w_two_n;
      r_stop2  <= w_stop2_n;
      r_brk    <= w_brk_n;
      if (baud_clock) r_samp <= {r_samp[1:0], rx};
    end
  end

  assign w_full    = (r_count == NW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = rd_if.rd_en && !w_empty;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_set_ovf = w_push && w_full && !w_pop;

  // FIFO storage write; contents need no reset because the head is gated by count
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a set event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow      <= 1'b0;
      r_parity_err    <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      if (w_set_ovf)       r_overflow <= 1'b1;
      else if (clr_errors) r_overflow <= 1'b0;
      if (w_set_par)       r_parity_err <= 1'b1;
      else if (clr_errors) r_parity_err <= 1'b0;
      if (w_set_frm)       r_framing_error <= 1'b1;
      else if (clr_errors) r_framing_error <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  // Sticky break flag
  always_ff @(posedge clk) begin
    if (!reset_n)        r_break_det <= 1'b0;
    else if (w_set_brk)  r_break_det <= 1'b1;
    else if (clr_errors) r_break_det <= 1'b0;
  end
  assign break_det = r_break_det;
`endif

  assign rd_if.rx_data    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign rd_if.rx_valid   = !w_empty;
  assign rd_if.fifo_count = r_count;
  assign overflow         = r_overflow;
  assign parity_err       = r_parity_err;
  assign framing_error    = r_framing_error;
  assign rx_idle          = (r_state == S_IDLE);
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_uart_rx_async_gen.sv
// Self-checking bench for uart_rx_async_gen with a frame-level reference model.
module tb_uart_rx_async_gen;
  localparam int MAX_BITS   = 9;
  localparam int OVS        = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV        = 4;
  localparam int BIT_CLKS   = OVS * DIV;

  // Clock / reset / baud tick
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] div = 2'd0;
  logic baud_clock;
  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign baud_clock = (div == 2'd3);

  logic [3:0] data_bits = 4'd8;
  logic parity_en = 1'b0, odd_n_even = 1'b0, two_stop = 1'b0;
  logic rx = 1'b1, clr_errors = 1'b0;
  logic overflow, parity_err, framing_error, rx_idle;
  logic [2:0] dbg_state;
`ifdef UART_RX_BREAK_DETECT_EN
  logic break_det;
`endif

  uart_rx_async_gen_if #(.MAX_BITS(MAX_BITS), .FIFO_DEPTH(FIFO_DEPTH)) rif ();

  uart_rx_async_gen #(.MAX_BITS(MAX_BITS), .OVS(OVS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock),
    .data_bits(data_bits), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .two_stop(two_stop), .rx(rx), .clr_errors(clr_errors), .rd_if(rif),
    .overflow(overflow), .parity_err(parity_err), .framing_error(framing_error),
    .rx_idle(rx_idle),
`ifdef UART_RX_BREAK_DETECT_EN
    .break_det(break_det),
`endif
    .dbg_state(dbg_state)
  );

  // Scoreboard and reference model state
  logic [MAX_BITS-1:0] exp_q[$];
  logic m_ovf = 1'b0, m_par = 1'b0, m_frm = 1'b0;
  int checks = 0;
  int passed = 0;

  function automatic int clamp_bits(input int v);
    if (v < 5) return 5;
    if (v > MAX_BITS) return MAX_BITS;
    return v;
  endfunction

  // Frame-level model: what one received frame does to the FIFO and flags
  task automatic model_frame(input logic [MAX_BITS-1:0] md, input logic pe, input logic bad_par,
                             input logic two, input logic s1, input logic s2);
    if (exp_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(md);
    if (pe && bad_par) m_par = 1'b1;
    if (!s1 || (two && !s2)) m_frm = 1'b1;
  endtask

  // Driver tasks (all start and end on a negedge)
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [MAX_BITS-1:0] d, input logic [3:0] nb, input logic pe,
                            input logic od, input logic two, input logic bad_par,
                            input logic s1, input logic s2, input bit scramble);
    int eff;
    logic [MAX_BITS-1:0] md;
    logic pbit;
    eff = clamp_bits(int'(nb));
    md = d & ((9'd1 << eff) - 9'd1);
    pbit = (^md) ^ od ^ bad_par;
    data_bits = nb; parity_en = pe; odd_n_even = od; two_stop = two;
    drive_bit(1'b0);
    if (scramble) begin
      data_bits = 4'($urandom_range(0, 15)); parity_en = 1'($urandom);
      odd_n_even = 1'($urandom); two_stop = 1'($urandom);
    end
    for (int i = 0; i < eff; i++) drive_bit(md[i]);
    if (pe) drive_bit(pbit);
    drive_bit(s1);
    if (two) drive_bit(s2);
    if (!s1 || (two && !s2)) drive_bit(1'b1);
    rx = 1'b1;
    model_frame(md, pe, bad_par, two, s1, s2);
  endtask

  task automatic do_pop();
    rif.rd_en = 1'b1;
    @(negedge clk);
    rif.rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic do_clr();
    clr_errors = 1'b1;
    @(negedge clk);
    clr_errors = 1'b0;
    m_ovf = 1'b0; m_par = 1'b0; m_frm = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rif.rd_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rx_idle !== 1'b1) $display("FAIL reset_rx_idle got=%b exp=1", rx_idle); else passed++;
    checks++; if (rif.rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", rif.rx_valid); else passed++;
    checks++; if (rif.fifo_count !== '0) $display("FAIL reset_count got=%0d exp=0", rif.fifo_count); else passed++;
    checks++; if ({overflow, parity_err, framing_error} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {overflow, parity_err, framing_error}); else passed++;
    checks++; if (rif.rx_data !== '0) $display("FAIL reset_rx_data got=%h exp=0", rif.rx_data); else passed++;
    checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else passed++;
    reset_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_8n1();
    logic [7:0] b;
    b = 8'hA5;
    data_bits = 4'd8; parity_en = 1'b0; two_stop = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    checks++; if (rif.rx_valid !== 1'b0) $display("FAIL 8n1_valid_before_stop got=%b exp=0", rif.rx_valid); else passed++;
    drive_bit(1'b1);
    model_frame(9'(b), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (rif.rx_valid !== 1'b1) $display("FAIL 8n1_valid got=%b exp=1", rif.rx_valid); else passed++;
    checks++; if (rif.rx_data !== exp_q[0]) $display("FAIL 8n1_data got=%h exp=%h", rif.rx_data, exp_q[0]); else passed++;
    checks++; if ({overflow, parity_err, framing_error} !== {m_ovf, m_par, m_frm})
      $display("FAIL 8n1_flags got=%b exp=%b", {overflow, parity_err, framing_error}, {m_ovf, m_par, m_frm}); else passed++;
    do_pop();
    checks++; if (rif.rx_valid !== 1'b0) $display("FAIL 8n1_valid_after_pop got=%b exp=0", rif.rx_valid); else passed++;
  endtask

  task automatic test_parity_7e1();
    send_frame(9'h041, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (rif.rx_data !== exp_q[0]) $display("FAIL 7e1_data got=%h exp=%h", rif.rx_data, exp_q[0]); else passed++;
    checks++; if (parity_err !== m_par) $display("FAIL 7e1_parity_err got=%b exp=%b", parity_err, m_par); else passed++;
    checks++; if (framing_error !== m_frm) $display("FAIL 7e1_framing got=%b exp=%b", framing_error, m_frm); else passed++;
    do_clr();
    checks++; if (parity_err !== 1'b0) $display("FAIL 7e1_clr got=%b exp=0", parity_err); else passed++;
    do_pop();
  endtask

  task automatic test_false_start();
    bit saw_start;
    saw_start = 0;
    rx = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < BIT_CLKS && !saw_start; i++) begin
      if (rx_idle === 1'b0) saw_start = 1;
      @(negedge clk);
    end
    checks++; if (!saw_start) $display("FAIL false_start_entered got=idle exp=start within %0d clks", BIT_CLKS); else passed++;
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (rx_idle !== 1'b1) $display("FAIL false_start_idle got=%b exp=1", rx_idle); else passed++;
    checks++; if (rif.fifo_count !== '0) $display("FAIL false_start_count got=%0d exp=0", rif.fifo_count); else passed++;
    checks++; if ({overflow, parity_err, framing_error} !== 3'b000)
      $display("FAIL false_start_flags got=%b exp=000", {overflow, parity_err, framing_error}); else passed++;
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++)
      send_frame(9'(k * 8'h11), 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (rif.fifo_count !== CW'(exp_q.size())) $display("FAIL ovf_count got=%0d exp=%0d", rif.fifo_count, exp_q.size()); else passed++;
    checks++; if (overflow !== m_ovf) $display("FAIL ovf_flag got=%b exp=%b", overflow, m_ovf); else passed++;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      checks++; if (rif.rx_data !== exp_q[0]) $display("FAIL ovf_read%0d got=%h exp=%h", k, rif.rx_data, exp_q[0]); else passed++;
      do_pop();
    end
    checks++; if (rif.rx_valid !== 1'b0) $display("FAIL ovf_drained got=%b exp=0", rif.rx_valid); else passed++;
    do_clr();
  endtask

  task automatic test_9n2_push_pop();
    bit saw_push;
    saw_push = 0;
    for (int k = 0; k < FIFO_DEPTH; k++)
      send_frame(9'($urandom_range(1, 511)), 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (rif.fifo_count !== CW'(FIFO_DEPTH)) $display("FAIL 9n2_full got=%0d exp=%0d", rif.fifo_count, FIFO_DEPTH); else passed++;
    fork
      send_frame(9'h1FF, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 14 * BIT_CLKS && !saw_push; i++) begin
          if (dut.w_push === 1'b1) begin
            saw_push = 1;
            do_pop();
          end else begin
            @(negedge clk);
          end
        end
      end
    join
    checks++; if (!saw_push) $display("FAIL 9n2_push_seen got=none exp=push within %0d clks", 14 * BIT_CLKS); else passed++;
    checks++; if (rif.fifo_count !== CW'(exp_q.size())) $display("FAIL 9n2_count got=%0d exp=%0d", rif.fifo_count, exp_q.size()); else passed++;
    checks++; if (overflow !== m_ovf) $display("FAIL 9n2_overflow got=%b exp=%b", overflow, m_ovf); else passed++;
    checks++; if (framing_error !== m_frm) $display("FAIL 9n2_framing got=%b exp=%b", framing_error, m_frm); else passed++;
    while (exp_q.size() > 0) begin
      checks++; if (rif.rx_data !== exp_q[0]) $display("FAIL 9n2_read got=%h exp=%h", rif.rx_data, exp_q[0]); else passed++;
      do_pop();
    end
    do_clr();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(9'h0F0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    data_bits = 4'd8;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rx = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0; m_par = 1'b0; m_frm = 1'b0;
    checks++; if (rx_idle !== 1'b1) $display("FAIL rstmid_idle got=%b exp=1", rx_idle); else passed++;
    checks++; if (rif.fifo_count !== '0) $display("FAIL rstmid_count got=%0d exp=0", rif.fifo_count); else passed++;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (rif.fifo_count !== 1) $display("FAIL rstmid_count2 got=%0d exp=1", rif.fifo_count); else passed++;
    checks++; if (rif.rx_data !== exp_q[0]) $display("FAIL rstmid_data got=%h exp=%h", rif.rx_data, exp_q[0]); else passed++;
    do_pop();
  endtask

  task automatic test_random();
    logic [MAX_BITS-1:0] d;
    logic [3:0] nb;
    logic pe, od, two, bad, s1, s2;
    for (int n = 0; n < 10; n++) begin
      d = 9'($urandom); nb = 4'($urandom_range(3, 15));
      pe = 1'($urandom); od = 1'($urandom); two = 1'($urandom);
      bad = pe && ($urandom_range(0, 3) == 0);
      s1 = ($urandom_range(0, 5) != 0);
      s2 = two ? ($urandom_range(0, 5) != 0) : 1'b1;
      if (!s1) d[0] = 1'b1;
      send_frame(d, nb, pe, od, two, bad, s1, s2, 1'b1);
      checks++; if (rif.rx_valid !== 1'b1) $display("FAIL rnd%0d_valid got=%b exp=1", n, rif.rx_valid); else passed++;
      checks++; if (rif.rx_data !== exp_q[0]) $display("FAIL rnd%0d_data got=%h exp=%h nb=%0d", n, rif.rx_data, exp_q[0], nb); else passed++;
      checks++; if ({overflow, parity_err, framing_error} !== {m_ovf, m_par, m_frm})
        $display("FAIL rnd%0d_flags got=%b exp=%b", n, {overflow, parity_err, framing_error}, {m_ovf, m_par, m_frm}); else passed++;
      do_pop();
      do_clr();
      repeat ($urandom_range(0, BIT_CLKS)) @(negedge clk);
    end
  endtask

  initial begin
    rif.rd_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity_7e1();
    test_false_start();
    test_overflow();
    test_9n2_push_pop();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
